// File: rtl/muldiv.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide, one bit
// per cycle plus a sign-fix cycle; divide-by-zero and signed overflow finish immediately.
module muldiv #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic            word_i,
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   input  logic [4:0]      rd_i,
   input  logic            kill_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);
   localparam int unsigned HW = XLEN / 2;
   localparam int unsigned AW = 2 * XLEN;
   localparam int unsigned CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      f3_q, f3_d;
   logic            word_q, word_d, neg_q, neg_d, busy_q, busy_d, done_q, done_d;
   logic [4:0]      tag_q, tag_d, rdo_q, rdo_d;
   logic [XLEN-1:0] b_q, b_d, res_q, res_d;
   logic [AW-1:0]   acc_q, acc_d;

   function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
      return {{HW{v[HW-1]}}, v[HW-1:0]};
   endfunction

   // Request decode: operand extension, magnitudes, result sign and fast-path detection
   logic [2:0]      f3_eff;
   logic            s1_signed, s2_signed, sign1, sign2, is_div, is_rem;
   logic            div_zero, div_ovf, accept;
   logic [XLEN-1:0] op1, op2, mag1, mag2, min_v, fast_res;

   always_comb begin
      f3_eff    = (word_i && !funct3_i[2]) ? 3'd0 : funct3_i;
      is_div    = f3_eff[2];
      is_rem    = f3_eff[2] & f3_eff[1];
      s1_signed = !(f3_eff == 3'd3 || (f3_eff[2] && f3_eff[0]));
      s2_signed = s1_signed && (f3_eff != 3'd2);
      op1       = src1_i;
      op2       = src2_i;
      min_v     = {1'b1, {(XLEN-1){1'b0}}};
      if (word_i) begin
         op1   = s1_signed ? sext_w(src1_i) : {{HW{1'b0}}, src1_i[HW-1:0]};
         op2   = s2_signed ? sext_w(src2_i) : {{HW{1'b0}}, src2_i[HW-1:0]};
         min_v = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};
      end
      sign1    = s1_signed & op1[XLEN-1];
      sign2    = s2_signed & op2[XLEN-1];
      mag1     = sign1 ? -op1 : op1;
      mag2     = sign2 ? -op2 : op2;
      div_zero = is_div && (op2 == '0);
      div_ovf  = is_div && !f3_eff[0] && (op1 == min_v) && (op2 == '1);
      if (div_zero)
         fast_res = is_rem ? (word_i ? sext_w(src1_i) : src1_i) : '1;
      else
         fast_res = is_rem ? '0 : op1;
      accept = (state_q == S_IDLE || state_q == S_DONE) && start_i && !kill_i;
   end

   // One iteration step and the final sign fix / result select
   logic [XLEN:0]   sum, rem_sh;
   logic            ge;
   logic [AW-1:0]   step, prod;
   logic [XLEN-1:0] wprod, quot, remd, raw, fix_res;

   always_comb begin
      sum    = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      rem_sh = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
      ge     = rem_sh >= {1'b0, b_q};
      if (f3_q[2])
         step = {(ge ? XLEN'(rem_sh - {1'b0, b_q}) : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};
      else
         step = {sum, acc_q[XLEN-1:1]};
      // After HW multiply steps the 64-bit product sits HW bits up in the accumulator
      prod  = neg_q ? -acc_q : acc_q;
      wprod = neg_q ? -acc_q[AW-HW-1:HW] : acc_q[AW-HW-1:HW];
      quot  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      remd  = neg_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
      case (f3_q)
         3'd0:             raw = word_q ? wprod : prod[XLEN-1:0];
         3'd1, 3'd2, 3'd3: raw = prod[AW-1:XLEN];
         3'd4, 3'd5:       raw = quot;
         default:          raw = remd;
      endcase
      fix_res = word_q ? sext_w(raw) : raw;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: state_d = accept ? ((div_zero || div_ovf) ? S_DONE : S_CALC) : S_IDLE;
         S_CALC: begin
            if (kill_i)                  state_d = S_IDLE;
            else if (cnt_q == CW'(1))    state_d = S_FIX;
         end
         S_FIX:   state_d = kill_i ? S_IDLE : S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      f3_d   = f3_q;
      word_d = word_q;
      neg_d  = neg_q;
      tag_d  = tag_q;
      b_d    = b_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      res_d  = res_q;
      rdo_d  = rdo_q;
      busy_d = (state_d == S_CALC) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
      if (accept) begin
         f3_d   = f3_eff;
         word_d = word_i;
         tag_d  = rd_i;
         b_d    = mag2;
         neg_d  = is_rem ? sign1 : (sign1 ^ sign2);
         // W divides start with the 32-bit dividend at the top so quotient bits land low
         acc_d  = {{XLEN{1'b0}}, ((is_div && word_i) ? (mag1 << HW) : mag1)};
         cnt_d  = word_i ? CW'(HW) : CW'(XLEN);
         if (div_zero || div_ovf) begin
            res_d = fast_res;
            rdo_d = rd_i;
         end
      end else if (state_q == S_CALC && !kill_i) begin
         cnt_d = cnt_q - CW'(1);
         acc_d = step;
      end else if (state_q == S_FIX && !kill_i) begin
         res_d = fix_res;
         rdo_d = tag_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         f3_q   <= '0;
         word_q <= 1'b0;
         neg_q  <= 1'b0;
         tag_q  <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         res_q  <= '0;
         rdo_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         f3_q   <= f3_d;
         word_q <= word_d;
         neg_q  <= neg_d;
         tag_q  <= tag_d;
         b_q    <= b_d;
         acc_q  <= acc_d;
         res_q  <= res_d;
         rdo_q  <= rdo_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = res_q;
   assign rd_o     = rdo_q;

endmodule
